isqrt_share_arbiter: RTL

- Shares one fixed_isqrt instance between NUM_REQ normalization lanes, for example several rms_norm_2d or layer-norm channels producing mean-square values.
- Arbitrates requests round-robin and records a requester tag for every accepted request in an in-order tag FIFO.
- Routes each isqrt result back to the lane that issued it.
- Sits between the per-lane mean registers and the shared inverse-sqrt unit.

---
 rtl/normalization_pkg.sv | 7 +
 rtl/isqrt_tag_fifo.sv | 39 +++
 rtl/isqrt_share_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/normalization_pkg.sv
// normalization_pkg: shared constants and helpers for the normalization datapath
package normalization_pkg;
  localparam int MAX_OUTSTANDING_DEF = 8;
  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/isqrt_tag_fifo.sv
// isqrt_tag_fifo: in-order requester-tag FIFO (push/din in; head, empty, full, count out)
module isqrt_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/isqrt_share_arbiter.sv
// isqrt_share_arbiter: round-robin share of one isqrt unit across NUM_REQ lanes (req_* in, isqrt_in_* out, isqrt_out_* in, resp_* out, outstanding/err_orphan status)
module isqrt_share_arbiter
  import normalization_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int DATA_WIDTH      = 16,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int TAG_WIDTH       = tag_width(NUM_REQ)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [DATA_WIDTH-1:0]                isqrt_in_data,
  output logic                                 isqrt_in_valid,
  input  logic                                 isqrt_in_ready,
  input  logic [DATA_WIDTH-1:0]                isqrt_out_data,
  input  logic                                 isqrt_out_valid,
  output logic                                 isqrt_out_ready,
  output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   resp_data,
  output logic [NUM_REQ-1:0]                   resp_valid,
  input  logic [NUM_REQ-1:0]                   resp_ready,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
  output logic                                 err_orphan
);
  logic [TAG_WIDTH-1:0] rr_ptr, locked_idx, gnt, head;
  logic lock, found, empty, full, push, pop;
  logic [NUM_REQ-1:0] head_sel;
  always_comb begin
    int j;
    j = 0;
    found = 1'b0;
    gnt = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        gnt = TAG_WIDTH'(j);
      end
    end
    if (lock) begin
      found = 1'b1;
      gnt = locked_idx;
    end
    // A held grant never meets a full FIFO: full only grows through a handshake, which clears lock.
    found = found && !full && !rst;
  end
  assign isqrt_in_valid = found;
  assign isqrt_in_data = req_data[gnt];
  assign push = isqrt_in_valid && isqrt_in_ready;
  always_comb begin
    req_ready = '0;
    head_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = push && (gnt == TAG_WIDTH'(i));
      head_sel[i] = !empty && (head == TAG_WIDTH'(i));
    end
  end
  assign resp_valid = isqrt_out_valid ? head_sel : '0;
  assign resp_data = {NUM_REQ{isqrt_out_data}};
  assign isqrt_out_ready = |(head_sel & resp_ready);
  assign pop = isqrt_out_valid && isqrt_out_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      lock <= 1'b0;
      locked_idx <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr <= (gnt == TAG_WIDTH'(NUM_REQ-1)) ? '0 : gnt + 1'b1;
        lock <= 1'b0;
      end else if (isqrt_in_valid) begin
        lock <= 1'b1;
        locked_idx <= gnt;
      end
      if (isqrt_out_valid && empty) err_orphan <= 1'b1;
    end
  end
  isqrt_tag_fifo #(.WIDTH(TAG_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(gnt),
    .pop(pop),
    .head(head),
    .empty(empty),
    .full(full),
    .count(outstanding)
  );
endmodule
